// File: rtl/ahb_sram_slv.sv
// AHB responder over a word-organised register array: programmable wait states,
// byte/halfword lane writes, two-cycle ERROR response. Optional write protection: AHB_SRAM_PROT_EN.
module ahb_sram_slv #(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] PROT_BASE   = 16'hC000
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [2:0]  hburst_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hready_o,
    output logic [1:0]  hresp_o,
    output logic [31:0] hrdata_o
);

    // state | meaning
    // IDLE  | no data phase pending
    // WAIT  | OKAY data phase stalled, counter running
    // DATA  | data phase completes this cycle
    // ERR1  | first ERROR cycle, hready low
    // ERR2  | second ERROR cycle, hready high
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [14:0] DEPTH_W = 15'(MEM_DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [AW+1:0]   r_addr;
    logic [1:0]      r_size;
    logic            r_write;
    logic [31:0]     r_mem [MEM_DEPTH];

    logic            w_accept;
    logic            w_take;
    logic            w_err;
    logic            w_prot_err;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic            w_unused;

`ifdef AHB_SRAM_PROT_EN
    assign w_prot_err = hwrite_i && (haddr_i[15:0] >= PROT_BASE);
    assign w_unused   = ^{haddr_i[31:16], hburst_i, htrans_i[0]};
`else
    assign w_prot_err = 1'b0;
    assign w_unused   = ^{haddr_i[31:16], hburst_i, htrans_i[0], PROT_BASE};
`endif

    assign w_accept = hsel_i && hready_i && htrans_i[1];

    assign w_err = (hsize_i > 3'b010)
                || ((hsize_i == 3'b001) && haddr_i[0])
                || ((hsize_i == 3'b010) && (haddr_i[1:0] != 2'b00))
                || ({1'b0, haddr_i[15:2]} >= DEPTH_W)
                || w_prot_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_take = 1'b1;
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WS_LOAD;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_addr  <= haddr_i[AW+1:0];
                r_size  <= hsize_i[1:0];
                r_write <= hwrite_i;
            end
        end
    end

    assign w_idx = r_addr[AW+1:2];

    always_comb begin
        case (r_size)
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Array has no reset; a reset on the DATA edge drops the pending write.
    always_ff @(posedge hclk) begin
        if (!hreset && (r_state == ST_DATA) && r_write) begin
            for (int n = 0; n < 4; n++) begin
                if (w_be[n]) begin
                    r_mem[w_idx][8*n +: 8] <= hwdata_i[8*n +: 8];
                end
            end
        end
    end

    assign hready_o = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    assign hresp_o  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    assign hrdata_o = (r_state == ST_DATA) ? r_mem[w_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Self-checking bench for ahb_sram_slv: directed vector table, hand-written reset/stall
// sequences and randomized single transfers checked against a byte-lane memory model.
module tb_ahb_sram_slv;

    localparam int D0  = 256;
    localparam int D1  = 16384;
    localparam int WS1 = 3;
`ifdef AHB_SRAM_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hreset = 1'b1;
    logic        hsel0 = 1'b0, hsel1 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;
    logic        stall_ext = 1'b0;

    logic        hready_o0, hready_o1;
    logic [1:0]  hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic        hready_bus;
    logic [1:0]  hresp_bus;
    logic [31:0] hrdata_bus;

    assign hready_bus = hready_o0 & hready_o1 & ~stall_ext;
    assign hresp_bus  = hresp0 | hresp1;
    assign hrdata_bus = hrdata0 | hrdata1;

    ahb_sram_slv #(.MEM_DEPTH(D0), .WAIT_STATES(0), .PROT_BASE(16'hC000)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel_i(hsel0), .haddr_i(haddr), .htrans_i(htrans),
        .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
        .hready_i(hready_bus), .hready_o(hready_o0), .hresp_o(hresp0), .hrdata_o(hrdata0)
    );

    ahb_sram_slv #(.MEM_DEPTH(D1), .WAIT_STATES(WS1), .PROT_BASE(16'hC000)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .hsel_i(hsel1), .haddr_i(haddr), .htrans_i(htrans),
        .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
        .hready_i(hready_bus), .hready_o(hready_o1), .hresp_o(hresp1), .hrdata_o(hrdata1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // per-beat observations from run_burst
    logic [31:0] bw [4];
    logic [31:0] brd [4];
    logic [1:0]  bresp [4];
    int          bnlow [4];
    int          bnerr [4];

    // reference memory: one entry per word, with per-byte known mask
    logic [31:0] mem_m [2][16384];
    logic [3:0]  mem_v [2][16384];

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] wdata;
        logic        err;
        int          mode;   // 0 no data check, 1 equal, 2 not equal
        logic [31:0] rd;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        n_cmp++;
        if (act === bad) begin
            n_bad++;
            $display("FAIL %s: got %h, expected anything but %h", name, act, bad);
        end
    endtask

    function automatic void model_write(input logic sel, input logic [31:0] a,
                                        input logic [2:0] sz, input logic [31:0] d);
        int off   = int'(a[15:0]);
        int idx   = off / 4;
        int first = off % 4;
        int nb    = 1 << sz;
        for (int b = first; b < first + nb; b++) begin
            mem_m[sel][idx][8*b +: 8] = d[8*b +: 8];
            mem_v[sel][idx][b]        = 1'b1;
        end
    endfunction

    function automatic logic exp_err(input logic sel, input logic wr,
                                     input logic [31:0] a, input logic [2:0] sz);
        int   off   = int'(a[15:0]);
        int   depth = sel ? D1 : D0;
        logic e     = 1'b0;
        if (sz > 3'd2) e = 1'b1;
        else if ((off % (1 << sz)) != 0) e = 1'b1;
        if ((off / 4) >= depth) e = 1'b1;
        if (PROT && wr && (off >= 'hC000)) e = 1'b1;
        return e;
    endfunction

    // Pipelined master: n beats, address of beat i overlaps data phase of beat i-1.
    // Entered and left at posedge+1.
    task automatic run_burst(input logic sel, input logic wr, input logic [31:0] base,
                             input logic [2:0] sz, input int n);
        int incr = 1 << sz[1:0];
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel0  = ~sel;
                hsel1  = sel;
                htrans = (i == 0) ? 2'b10 : 2'b11;
                haddr  = base + 32'(i * incr);
                hwrite = wr;
                hsize  = sz;
                hburst = (n > 1) ? 3'b011 : 3'b000;
            end else begin
                hsel0  = 1'b0;
                hsel1  = 1'b0;
                htrans = 2'b00;
            end
            if (i > 0) begin
                hwdata     = bw[i-1];
                bnlow[i-1] = 0;
                bnerr[i-1] = 0;
            end
            begin
                int guard = 0;
                @(negedge hclk);
                while (!hready_bus) begin
                    if (i > 0) begin
                        bnlow[i-1]++;
                        if (hresp_bus == 2'b01) bnerr[i-1]++;
                    end
                    guard++;
                    if (guard > 64) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL timeout: hready stuck low, beat %0d", i);
                        break;
                    end
                    @(negedge hclk);
                end
                if (i > 0) begin
                    brd[i-1]   = hrdata_bus;
                    bresp[i-1] = hresp_bus;
                end
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic expect_beat(input string name, input int i, input logic err,
                               input int ws, input int mode, input logic [31:0] exp_rd);
        chk({name, "/wait"},   32'(bnlow[i]), err ? 32'd1 : 32'(ws));
        chk({name, "/lowerr"}, 32'(bnerr[i]), err ? 32'd1 : 32'd0);
        chk({name, "/resp"},   32'(bresp[i]), err ? 32'd1 : 32'd0);
        if (mode == 1)      chk({name, "/rdata"}, brd[i], exp_rd);
        else if (mode == 2) chk_ne({name, "/rdata"}, brd[i], exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sel, wr, e;
        logic [2:0]  sz;
        logic [31:0] a, d;
        int          mode;

        vt[0]  = '{1'b0, 1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 1'b0, 0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h10,   3'd2, 32'h0,        1'b0, 1, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 1'b1, 32'h10,   3'd2, 32'h11223344, 1'b0, 0, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 32'h13,   3'd0, 32'hAA000000, 1'b0, 0, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 32'h10,   3'd2, 32'h0,        1'b0, 1, 32'hAA223344};
        vt[5]  = '{1'b0, 1'b1, 32'h10,   3'd1, 32'h00005566, 1'b0, 0, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 32'h10,   3'd2, 32'h0,        1'b0, 1, 32'hAA225566};
        vt[7]  = '{1'b0, 1'b0, 32'h400,  3'd2, 32'h0,        1'b1, 1, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 32'h01,   3'd1, 32'h0,        1'b1, 1, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 32'h11,   3'd1, 32'hFFFFFFFF, 1'b1, 0, 32'h0};
        vt[10] = '{1'b0, 1'b1, 32'h10,   3'd3, 32'hFFFFFFFF, 1'b1, 0, 32'h0};
        vt[11] = '{1'b0, 1'b1, 32'h12,   3'd2, 32'hFFFFFFFF, 1'b1, 0, 32'h0};
        vt[12] = '{1'b0, 1'b0, 32'h10,   3'd2, 32'h0,        1'b0, 1, 32'hAA225566};
        vt[13] = '{1'b0, 1'b0, 32'h12,   3'd1, 32'h0,        1'b0, 1, 32'hAA225566};
        vt[14] = '{1'b1, 1'b1, 32'hC000, 3'd2, 32'h12345678, PROT, 0, 32'h0};
        vt[15] = '{1'b1, 1'b0, 32'hC000, 3'd2, 32'h0,        1'b0, PROT ? 2 : 1, 32'h12345678};

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16384; w++) mem_v[s][w] = 4'h0;
        end

        // reset state
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rst/hready0", 32'(hready_o0), 32'd1);
        chk("rst/hready1", 32'(hready_o1), 32'd1);
        chk("rst/hresp",   32'(hresp_bus), 32'd0);
        chk("rst/hrdata",  hrdata_bus,     32'h0);
        @(posedge hclk);
        #1;

        // directed vector table
        for (int i = 0; i < 16; i++) begin
            bw[0] = vt[i].wdata;
            run_burst(vt[i].sel, vt[i].wr, vt[i].addr, vt[i].sz, 1);
            expect_beat($sformatf("vec%0d", i), 0, vt[i].err, vt[i].sel ? WS1 : 0,
                        vt[i].mode, vt[i].rd);
            if (vt[i].wr && !vt[i].err) model_write(vt[i].sel, vt[i].addr, vt[i].sz, vt[i].wdata);
        end

        // INCR4 bursts on both slaves
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 4; b++) bw[b] = $urandom;
            run_burst(s[0], 1'b1, 32'h0, 3'd2, 4);
            for (int b = 0; b < 4; b++) begin
                expect_beat($sformatf("incr4w%0d_%0d", s, b), b, 1'b0, s ? WS1 : 0, 0, 32'h0);
                model_write(s[0], 32'(4 * b), 3'd2, bw[b]);
            end
            run_burst(s[0], 1'b0, 32'h0, 3'd2, 4);
            for (int b = 0; b < 4; b++)
                expect_beat($sformatf("incr4r%0d_%0d", s, b), b, 1'b0, s ? WS1 : 0, 1,
                            mem_m[s][b]);
        end

        // BUSY while selected: no data phase, no write
        hsel0 = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        hwdata = 32'h0BADF00D;
        @(posedge hclk);
        #1 hsel0 = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("busy/hready0", 32'(hready_o0), 32'd1);
        @(posedge hclk);
        #1 run_burst(1'b0, 1'b0, 32'h10, 3'd2, 1);
        expect_beat("busy/read", 0, 1'b0, 0, 1, mem_m[0][4]);

        // hready_i low while idle: address phase must be ignored
        stall_ext = 1'b1;
        hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(posedge hclk);
        #1 hsel0 = 1'b0; htrans = 2'b00; stall_ext = 1'b0;
        @(negedge hclk);
        chk("stall/hready0", 32'(hready_o0), 32'd1);
        chk("stall/hresp",   32'(hresp_bus), 32'd0);
        @(posedge hclk);
        #1 run_burst(1'b0, 1'b0, 32'h10, 3'd2, 1);
        expect_beat("stall/read", 0, 1'b0, 0, 1, mem_m[0][4]);

        // reset during WAIT of a write to 0x20 on the wait-state slave
        bw[0] = 32'h0;
        run_burst(1'b1, 1'b1, 32'h20, 3'd2, 1);
        model_write(1'b1, 32'h20, 3'd2, 32'h0);
        hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        @(posedge hclk);
        #1 hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h55AA55AA;
        @(negedge hclk);
        chk("rstwait/inwait", 32'(hready_o1), 32'd0);
        hreset = 1'b1;
        @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rstwait/hready1", 32'(hready_o1), 32'd1);
        chk("rstwait/hresp",   32'(hresp1),    32'd0);
        @(posedge hclk);
        #1 run_burst(1'b1, 1'b0, 32'h20, 3'd2, 1);
        expect_beat("rstwait/read", 0, 1'b0, WS1, 1, 32'h0);

        // reset on the DATA edge of a zero-wait write drops the write
        bw[0] = 32'h01010101;
        run_burst(1'b0, 1'b1, 32'h14, 3'd2, 1);
        model_write(1'b0, 32'h14, 3'd2, 32'h01010101);
        hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h14; hsize = 3'd2;
        @(posedge hclk);
        #1 hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'hBADBAD00; hreset = 1'b1;
        @(posedge hclk);
        #1 hreset = 1'b0;
        run_burst(1'b0, 1'b0, 32'h14, 3'd2, 1);
        expect_beat("rstdata/read", 0, 1'b0, 0, 1, 32'h01010101);

        // random region fill, then random single transfers against the model
        for (int s = 0; s < 2; s++) begin
            for (int w = 64; w < 96; w++) begin
                bw[0] = $urandom;
                run_burst(s[0], 1'b1, 32'(4 * w), 3'd2, 1);
                expect_beat($sformatf("fill%0d_%0d", s, w), 0, 1'b0, s ? WS1 : 0, 0, 32'h0);
                model_write(s[0], 32'(4 * w), 3'd2, bw[0]);
            end
        end
        for (int t = 0; t < 200; t++) begin
            sel = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            sz  = 3'($urandom_range(0, 3));
            a   = {16'($urandom), 16'(32'h100 + $urandom_range(0, 127))};
            if ($urandom_range(0, 15) == 0) a[15:0] = 16'($urandom_range(32'h400, 32'hFFFF));
            d     = $urandom;
            bw[0] = d;
            e     = exp_err(sel, wr, a, sz);
            mode  = 0;
            if (e) mode = 1;
            else if (!wr && mem_v[sel][int'(a[15:2])] == 4'hF) mode = 1;
            run_burst(sel, wr, a, sz, 1);
            expect_beat($sformatf("rnd%0d", t), 0, e, sel ? WS1 : 0, mode,
                        e ? 32'h0 : mem_m[sel][int'(a[15:2])]);
            if (wr && !e) model_write(sel, a, sz, d);
            repeat ($urandom_range(0, 2)) @(posedge hclk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
